// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//
// Integer register file for the Deilt_RISCV core. It is the write-back endpoint
// of the mem_wb pipeline register. It has two combinational read ports for
// decode, with same-cycle write-back bypass. A handshaked debug port shares
// the single write port with write-back. Write-back always has priority, and a
// starved debug request raises a hold request towards ctrl.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   regs_wen_i        : write-back enable
//   rd_addr_i         : write-back destination address
//   rd_data_i         : write-back data
//   rs1/rs2_raddr_i   : decode read addresses
//   rs1/rs2_rdata_o   : combinational read data (x0 = 0, write-back bypass)
//   dbg_req_i         : debug request, held high until acknowledged (4-phase)
//   dbg_we_i          : debug direction, 1 = write, 0 = read
//   dbg_addr_i        : debug register address
//   dbg_wdata_i       : debug write data
//   dbg_ack_o         : registered acknowledge (high while FSM is in ACK)
//   dbg_rdata_o       : registered debug read data, valid while dbg_ack_o = 1
//   dbg_hold_o        : registered request to ctrl to freeze write-back
//   dbg_state_o       : current debug FSM state (0 = IDLE, 1 = ACK)
//
// Debug handshake: a request is accepted in IDLE on a cycle where dbg_req_i = 1
// and regs_wen_i = 0. dbg_ack_o rises on the following edge and stays high
// until dbg_req_i is seen low, after which the FSM returns to IDLE. Only IDLE
// can accept a new request.
// -----------------------------------------------------------------------------
module regfile #(
   parameter int RegWidth     = 32,
   parameter int RegAddrWidth = 5,
   parameter int DBG_WAIT_MAX = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    regs_wen_i,
   input  logic [RegAddrWidth-1:0] rd_addr_i,
   input  logic [RegWidth-1:0]     rd_data_i,
   input  logic [RegAddrWidth-1:0] rs1_raddr_i,
   input  logic [RegAddrWidth-1:0] rs2_raddr_i,
   output logic [RegWidth-1:0]     rs1_rdata_o,
   output logic [RegWidth-1:0]     rs2_rdata_o,
   input  logic                    dbg_req_i,
   input  logic                    dbg_we_i,
   input  logic [RegAddrWidth-1:0] dbg_addr_i,
   input  logic [RegWidth-1:0]     dbg_wdata_i,
   output logic                    dbg_ack_o,
   output logic [RegWidth-1:0]     dbg_rdata_o,
   output logic                    dbg_hold_o,
   output logic                    dbg_state_o
);

   localparam int          NumRegs  = 1 << RegAddrWidth;
   localparam logic [2:0]  WaitMax  = 3'(DBG_WAIT_MAX);
   localparam logic [2:0]  WaitSat  = 3'd7;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } dbg_state_t;

   // x0 is not stored; entries 1..NumRegs-1 only.
   logic [RegWidth-1:0]     r_regs [1:NumRegs-1];

   dbg_state_t              r_state;
   dbg_state_t              w_state_nxt;
   logic [2:0]              r_wait_cnt;
   logic [2:0]              w_wait_nxt;
   logic                    r_hold;
   logic                    w_hold_nxt;
   logic [RegWidth-1:0]     r_dbg_rdata;

   logic                    w_accept;
   logic                    w_wr_en;
   logic [RegAddrWidth-1:0] w_wr_addr;
   logic [RegWidth-1:0]     w_wr_data;
   logic [RegWidth-1:0]     w_dbg_stored;

   function automatic logic [RegWidth-1:0] stored_val(input logic [RegAddrWidth-1:0] addr);
      if (addr == '0) return '0;
      return r_regs[addr];
   endfunction

   function automatic logic [RegWidth-1:0] read_port(input logic [RegAddrWidth-1:0] addr);
      if (addr == '0) return '0;
      // Bypass only from write-back; debug writes land in storage first.
      if (regs_wen_i && (rd_addr_i == addr)) return rd_data_i;
      return r_regs[addr];
   endfunction

   assign rs1_rdata_o  = read_port(rs1_raddr_i);
   assign rs2_rdata_o  = read_port(rs2_raddr_i);
   assign w_dbg_stored = stored_val(dbg_addr_i);

   // Single write port: write-back, or an accepted debug write (which can only
   // be accepted on a cycle with regs_wen_i = 0). Writes to x0 are dropped.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = rd_addr_i;
      w_wr_data = rd_data_i;
      if (regs_wen_i) begin
         w_wr_en = (rd_addr_i != '0);
      end else if (w_accept && dbg_we_i) begin
         w_wr_en   = (dbg_addr_i != '0);
         w_wr_addr = dbg_addr_i;
         w_wr_data = dbg_wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NumRegs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[w_wr_addr] <= w_wr_data;
      end
   end

   // Debug FSM: next-state, wait counter and hold request.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_hold_nxt  = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (dbg_req_i) begin
               if (!regs_wen_i) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_ACK;
                  w_wait_nxt  = '0;
               end else if (r_wait_cnt != WaitSat) begin
                  w_wait_nxt = r_wait_cnt + 3'd1;
               end
            end else begin
               w_wait_nxt = '0;
            end
            // Hold goes up once the blocked count reaches the limit and drops
            // on the accepting edge (or when the request goes away).
            w_hold_nxt = dbg_req_i && regs_wen_i && (w_wait_nxt >= WaitMax);
         end
         S_ACK: begin
            w_wait_nxt = '0;
            if (!dbg_req_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_wait_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= '0;
         r_hold      <= 1'b0;
         r_dbg_rdata <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_hold     <= w_hold_nxt;
         if (w_accept && !dbg_we_i) begin
            r_dbg_rdata <= w_dbg_stored;
         end
      end
   end

   assign dbg_ack_o   = (r_state == S_ACK);
   assign dbg_rdata_o = r_dbg_rdata;
   assign dbg_hold_o  = r_hold;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          regs_wen_i;
  logic [AW-1:0] rd_addr_i;
  logic [W-1:0]  rd_data_i;
  logic [AW-1:0] rs1_raddr_i;
  logic [AW-1:0] rs2_raddr_i;
  logic [W-1:0]  rs1_rdata_o;
  logic [W-1:0]  rs2_rdata_o;
  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [W-1:0]  dbg_wdata_i;
  logic          dbg_ack_o;
  logic [W-1:0]  dbg_rdata_o;
  logic          dbg_hold_o;
  logic          dbg_state_o;

  int n_pass;
  int n_total;

  regfile #(
    .RegWidth     (W),
    .RegAddrWidth (AW),
    .DBG_WAIT_MAX (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .regs_wen_i  (regs_wen_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_i   (rd_data_i),
    .rs1_raddr_i (rs1_raddr_i),
    .rs2_raddr_i (rs2_raddr_i),
    .rs1_rdata_o (rs1_rdata_o),
    .rs2_rdata_o (rs2_rdata_o),
    .dbg_req_i   (dbg_req_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .dbg_ack_o   (dbg_ack_o),
    .dbg_rdata_o (dbg_rdata_o),
    .dbg_hold_o  (dbg_hold_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [AW-1:0] a, input logic [W-1:0] d);
    regs_wen_i = en;
    rd_addr_i  = a;
    rd_data_i  = d;
  endtask

  task automatic dbg(input logic req, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    dbg_req_i   = req;
    dbg_we_i    = we;
    dbg_addr_i  = a;
    dbg_wdata_i = d;
  endtask

  typedef struct {
    logic          wen;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [W-1:0]  exp1;
    logic [W-1:0]  exp2;
  } vec_t;

  vec_t vecs [11];

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Each vector is applied for one cycle; expectations are the combinational
    // read values during that cycle, given all earlier vectors have committed.
    vecs[0]  = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd6,  32'h12345678, 32'h00000000};
    vecs[1]  = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd6,  32'h12345678, 32'h00000000};
    vecs[2]  = '{1'b1, 5'd6,  32'hCAFEF00D, 5'd6,  5'd5,  32'hCAFEF00D, 32'h12345678};
    vecs[3]  = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[4]  = '{1'b0, 5'd0,  32'hDEADBEEF, 5'd0,  5'd6,  32'h00000000, 32'hCAFEF00D};
    vecs[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd6,  5'd7,  32'hCAFEF00D, 32'hA5A5A5A5};
    vecs[6]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd7,  32'hFFFFFFFF, 32'hA5A5A5A5};
    vecs[7]  = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd31, 32'h00000001, 32'h00000001};
    vecs[8]  = '{1'b0, 5'd31, 32'h00000BAD, 5'd31, 5'd1,  32'h00000001, 32'h00000000};
    vecs[9]  = '{1'b0, 5'd6,  32'h00000BAD, 5'd6,  5'd5,  32'hCAFEF00D, 32'h12345678};
    vecs[10] = '{1'b0, 5'd3,  32'h00000000, 5'd3,  5'd7,  32'h00000000, 32'hA5A5A5A5};

    rst = 1'b1;
    wb(1'b0, '0, '0);
    dbg(1'b0, 1'b0, '0, '0);
    rs1_raddr_i = 5'd5;
    rs2_raddr_i = 5'd31;
    #12;
    chk("reset_ack",   {31'd0, dbg_ack_o},   32'd0);
    chk("reset_hold",  {31'd0, dbg_hold_o},  32'd0);
    chk("reset_rdata", dbg_rdata_o,          32'd0);
    chk("reset_rs1",   rs1_rdata_o,          32'd0);
    chk("reset_rs2",   rs2_rdata_o,          32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // write-back / bypass / x0 table
    for (int i = 0; i < 11; i++) begin
      wb(vecs[i].wen, vecs[i].rd_addr, vecs[i].rd_data);
      rs1_raddr_i = vecs[i].rs1;
      rs2_raddr_i = vecs[i].rs2;
      #3;
      chk($sformatf("vec%0d_rs1", i), rs1_rdata_o, vecs[i].exp1);
      chk($sformatf("vec%0d_rs2", i), rs2_rdata_o, vecs[i].exp2);
      tick();
    end

    // debug read of x7
    wb(1'b0, '0, '0);
    dbg(1'b1, 1'b0, 5'd7, 32'h0);
    #3;
    chk("dread_ack_before", {31'd0, dbg_ack_o}, 32'd0);
    tick();
    chk("dread_ack",   {31'd0, dbg_ack_o},   32'd1);
    chk("dread_state", {31'd0, dbg_state_o}, 32'd1);
    chk("dread_data",  dbg_rdata_o,          32'hA5A5A5A5);
    wb(1'b1, 5'd7, 32'h0F0F0F0F);  // storage changes; captured data must not
    tick();
    wb(1'b0, '0, '0);
    chk("dread_ack_held",  {31'd0, dbg_ack_o}, 32'd1);
    chk("dread_data_held", dbg_rdata_o,        32'hA5A5A5A5);
    dbg(1'b0, 1'b0, 5'd7, 32'h0);
    #3;
    chk("dread_ack_drop_cycle", {31'd0, dbg_ack_o}, 32'd1);
    tick();
    chk("dread_ack_released", {31'd0, dbg_ack_o}, 32'd0);

    // debug write x3 colliding with write-back to x3 for two cycles
    wb(1'b1, 5'd3, 32'h22);
    dbg(1'b1, 1'b1, 5'd3, 32'h11);
    rs1_raddr_i = 5'd3;
    tick();
    chk("coll_ack_c1", {31'd0, dbg_ack_o}, 32'd0);
    tick();
    chk("coll_ack_c2", {31'd0, dbg_ack_o}, 32'd0);
    chk("coll_x3_wb",  rs1_rdata_o,        32'h22);
    wb(1'b0, '0, '0);
    tick();
    chk("coll_ack_c3",  {31'd0, dbg_ack_o}, 32'd1);
    chk("coll_hold",    {31'd0, dbg_hold_o}, 32'd0);
    chk("coll_x3_dbg",  rs1_rdata_o,        32'h11);
    dbg(1'b0, 1'b0, 5'd3, 32'h0);
    tick();
    chk("coll_ack_released", {31'd0, dbg_ack_o}, 32'd0);
    chk("coll_x3_final",     rs1_rdata_o,        32'h11);

    // debug write to x0 is dropped
    dbg(1'b1, 1'b1, 5'd0, 32'h55555555);
    rs1_raddr_i = 5'd0;
    tick();
    chk("x0_dbg_ack", {31'd0, dbg_ack_o}, 32'd1);
    chk("x0_dbg_rd",  rs1_rdata_o,        32'd0);
    dbg(1'b0, 1'b0, 5'd0, 32'h0);
    tick();

    // starvation: write-back to x9 keeps the debug read blocked
    wb(1'b1, 5'd9, 32'h99);
    dbg(1'b1, 1'b0, 5'd9, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("starve_hold_c%0d", c), {31'd0, dbg_hold_o}, (c >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("starve_ack_c%0d", c),  {31'd0, dbg_ack_o},  32'd0);
    end
    wb(1'b0, '0, '0);
    tick();
    chk("starve_hold_clear", {31'd0, dbg_hold_o}, 32'd0);
    chk("starve_ack",        {31'd0, dbg_ack_o},  32'd1);
    chk("starve_data",       dbg_rdata_o,         32'h99);
    dbg(1'b0, 1'b0, 5'd9, 32'h0);
    tick();
    chk("starve_ack_released", {31'd0, dbg_ack_o}, 32'd0);

    // reset while in ACK, request held high throughout
    dbg(1'b1, 1'b0, 5'd5, 32'h0);
    rs1_raddr_i = 5'd5;
    rs2_raddr_i = 5'd7;
    tick();
    chk("rack_ack_pre",  {31'd0, dbg_ack_o}, 32'd1);
    chk("rack_data_pre", dbg_rdata_o,        32'h12345678);
    #2;
    rst = 1'b1;
    #1;
    chk("rack_ack_async",  {31'd0, dbg_ack_o},  32'd0);
    chk("rack_hold_async", {31'd0, dbg_hold_o}, 32'd0);
    chk("rack_rdata_async", dbg_rdata_o,        32'd0);
    chk("rack_rs1_async",  rs1_rdata_o,         32'd0);
    chk("rack_rs2_async",  rs2_rdata_o,         32'd0);
    tick();
    rst = 1'b0;
    #3;
    chk("rack_ack_after_release", {31'd0, dbg_ack_o}, 32'd0);
    tick();
    chk("rack_reack",      {31'd0, dbg_ack_o}, 32'd1);
    chk("rack_reack_data", dbg_rdata_o,        32'd0);
    dbg(1'b0, 1'b0, 5'd5, 32'h0);
    tick();
    chk("rack_ack_released", {31'd0, dbg_ack_o}, 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Integer register file for the Deilt_RISCV core. It is the write-back endpoint of the mem_wb pipeline register and consumes its `regs_wen`/`rd_addr`/`rd_data` triple. It serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass. A handshaked debug access port shares the single write port with write-back; write-back has priority, and the debug port can request a pipeline hold from ctrl when it is starved.

## Interface
Parameters:
- `RegWidth`, 32, data width of each register.
- `RegAddrWidth`, 5, register address width (32 registers, x0..x31).
- `DBG_WAIT_MAX`, 3, number of consecutive blocked debug cycles before `dbg_hold_o` asserts (legal range 1..7).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `regs_wen_i` in 1: write-back enable from mem_wb.
- `rd_addr_i` in RegAddrWidth: write-back destination address.
- `rd_data_i` in RegWidth: write-back data.
- `rs1_raddr_i`, `rs2_raddr_i` in RegAddrWidth: decode-stage read addresses.
- `rs1_rdata_o`, `rs2_rdata_o` out RegWidth: read data, combinational.
- `dbg_req_i` in 1: debug request; held high until acknowledged.
- `dbg_we_i` in 1: 1 = write, 0 = read; sampled on acceptance.
- `dbg_addr_i` in RegAddrWidth: debug register address.
- `dbg_wdata_i` in RegWidth: debug write data.
- `dbg_ack_o` out 1: registered acknowledge.
- `dbg_rdata_o` out RegWidth: registered debug read data, valid while `dbg_ack_o`=1.
- `dbg_hold_o` out 1: registered request to ctrl to freeze mem_wb/write-back.

## Operation
- **Storage:** x1..x31 are flops. x0 is not stored, always reads 0, and writes to it are silently dropped.
- **Write-back:** when `regs_wen_i`=1 and `rd_addr_i`≠0, `rd_data_i` is written at the rising edge.
- **Read ports** (each port independently):
  - address 0 → 0;
  - else if `regs_wen_i`=1 and `rd_addr_i` equals the read address → `rd_data_i` (bypass);
  - else → stored value.
- **Debug FSM, IDLE:**
  - If `dbg_req_i`=1 and `regs_wen_i`=0, the request is accepted this cycle.
    - Write: commit `dbg_wdata_i` to `dbg_addr_i` at the edge (dropped if the address is 0).
    - Read: capture the stored value into `dbg_rdata_o`.
    - Go to ACK.
  - If `dbg_req_i`=1 and `regs_wen_i`=1, the request is blocked; increment `wait_cnt` (3-bit, saturating).
  - If `dbg_req_i`=0, clear `wait_cnt`.
- **Debug FSM, ACK:**
  - `dbg_ack_o`=1.
  - Stay in ACK until `dbg_req_i`=0 (4-phase handshake), then return to IDLE.
  - A new request is accepted only from IDLE.
- **Hold request:** `dbg_hold_o` is registered. It is 1 while in IDLE with `dbg_req_i`=1 and `wait_cnt`≥`DBG_WAIT_MAX`, and it clears on the edge that accepts the request.
- **Debug write bypass:** debug writes never bypass to the read ports. A read on the cycle after the commit sees the new value.
- **Reset** (asynchronous, immediate):
  - x1..x31 = 0;
  - FSM = IDLE, `wait_cnt` = 0;
  - `dbg_ack_o` = 0, `dbg_rdata_o` = 0, `dbg_hold_o` = 0;
  - read outputs reflect the zeroed storage.
- **Reset mid-operation:** reset asserted in ACK aborts the handshake. After release, a still-high `dbg_req_i` is treated as a new request.

## Timing
- **Read latency:** 0 cycles (combinational from address, storage and the write-back inputs).
- **Write-back:** visible in storage 1 edge after presentation, and visible through bypass in the same cycle.
- **Debug access:**
  - `dbg_ack_o` rises 1 cycle after the acceptance cycle.
  - Minimum request-to-ack is 1 cycle (`regs_wen_i`=0).
  - `dbg_rdata_o` is stable for the whole ACK state.
- **Simultaneous write-back and debug request:** write-back always wins, and the debug request is not accepted that cycle.
- **Hold timing:** `dbg_hold_o` rises on the edge after the `DBG_WAIT_MAX`-th consecutive blocked cycle. Once ctrl freezes write-back (`regs_wen_i`=0), the request is accepted the next cycle.
- **Saturation:** `wait_cnt` never wraps; it saturates at 7.

## Test plan
- **Reset and x0:**
  - Stimulus: assert `rst` async mid-cycle.
  - Required: all reads = 0 and `dbg_ack_o`/`dbg_hold_o` = 0 immediately.
  - Then write-back x0 with 0xDEADBEEF → reading x0 returns 0.
- **Write-back and bypass:**
  - Stimulus: `regs_wen_i`=1, `rd_addr_i`=5, `rd_data_i`=0x12345678, `rs1_raddr_i`=5, `rs2_raddr_i`=6.
  - Required: same cycle rs1=0x12345678 and rs2=old x6.
  - Next cycle with `regs_wen_i`=0: rs1 still 0x12345678.
- **Debug read:**
  - Stimulus: x7=0xA5A5A5A5, `dbg_req_i`=1, `dbg_we_i`=0, `dbg_addr_i`=7, idle pipeline.
  - Required: `dbg_ack_o`=1 next cycle with `dbg_rdata_o`=0xA5A5A5A5.
  - Ack holds until `dbg_req_i`=0 and drops the cycle after.
- **Debug write vs write-back collision:**
  - Stimulus: debug write x3=0x11 while `regs_wen_i`=1 to x3=0x22 for 2 cycles, then write-back idle.
  - Required: ack on the 4th cycle and final x3=0x11.
- **Starvation hold:**
  - Stimulus: `DBG_WAIT_MAX`=3, `regs_wen_i` held 1, debug request pending.
  - Required: `dbg_hold_o`=1 after 3 blocked cycles.
  - Then drop `regs_wen_i` → request accepted, `dbg_hold_o`=0 and ack next cycle.
- **Reset in ACK:**
  - Stimulus: assert `rst` while `dbg_ack_o`=1 and `dbg_req_i` stays high.
  - Required: `dbg_ack_o`=0 immediately, then re-ack 1 cycle after reset release.
